// File: rtl/mux_scan_capture_pkg.sv
// Shared types and sizing constants for the mux scan/capture sequencer.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  // Width of the mux select bus.
  localparam int SEL_W = 3;

  // Number of mux inputs walked per scan; tied to the 3-bit select.
  localparam int NUM_INPUTS = 8;

  // Hold counter width; covers hold counts 1..16 (terminal value 0..15).
  localparam int HOLD_W = 4;

endpackage

// File: rtl/mux_scan_capture_if.sv
// Bundle of control, mux-facing and result signals for the scan sequencer.
// The sequencer itself uses the slave modport; whatever drives start/abort
// and the downstream mux result uses the master modport.
interface mux_scan_capture_if;
  import mux_scan_pkg::*;

  logic                  Start_In;
  logic                  Loop_Mode_In;
  logic                  Abort_In;
  logic                  MUX_Result_Data_In;
  logic                  Enable_Out;
  logic [SEL_W-1:0]      Select_Out;
  logic                  Busy_Out;
  logic                  Done_Out;
  logic [NUM_INPUTS-1:0] Parallel_Data_Out;

  modport slave (
    input  Start_In,
    input  Loop_Mode_In,
    input  Abort_In,
    input  MUX_Result_Data_In,
    output Enable_Out,
    output Select_Out,
    output Busy_Out,
    output Done_Out,
    output Parallel_Data_Out
  );

  modport master (
    output Start_In,
    output Loop_Mode_In,
    output Abort_In,
    output MUX_Result_Data_In,
    input  Enable_Out,
    input  Select_Out,
    input  Busy_Out,
    input  Done_Out,
    input  Parallel_Data_Out
  );

endinterface

// File: rtl/mux_scan_capture.sv
// Walks an external 8:1 mux through inputs 0..7, samples its output for each
// select value (after HOLD_CYCLES settling cycles) and publishes the eight
// samples as a parallel word together with a one-cycle done pulse.
module mux_scan_capture
  import mux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic              Clock_In,
  input  logic              Reset_n_In,
  mux_scan_capture_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_INPUTS - 1);

  scan_state_t           state, state_next;
  logic [SEL_W-1:0]      sel, sel_next;
  logic [HOLD_W-1:0]     hold_cnt, hold_cnt_next;
  logic [NUM_INPUTS-1:0] capture, capture_next;
  logic [NUM_INPUTS-1:0] word, word_next;

  // Next-state logic: sequencing, hold counting and sample capture.
  always_comb begin
    state_next    = state;
    sel_next      = sel;
    hold_cnt_next = hold_cnt;
    capture_next  = capture;
    word_next     = word;

    case (state)
      IDLE: begin
        if (bus.Start_In) begin
          state_next    = SCAN;
          sel_next      = '0;
          hold_cnt_next = '0;
        end
      end

      SCAN: begin
        if (bus.Abort_In) begin
          // Abort wins even over a final sample; the partial word is dropped.
          state_next    = IDLE;
          sel_next      = '0;
          hold_cnt_next = '0;
          capture_next  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          // Sampling only happens here, where the mux enable is high.
          capture_next[sel] = bus.MUX_Result_Data_In;
          hold_cnt_next     = '0;
          if (sel == SEL_LAST) begin
            state_next = DONE;
            word_next  = capture_next;
          end else begin
            sel_next = sel + 1'b1;
          end
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end

      DONE: begin
        sel_next      = '0;
        hold_cnt_next = '0;
        capture_next  = '0;
        state_next    = bus.Loop_Mode_In ? SCAN : IDLE;
      end

      default: begin
        state_next    = IDLE;
        sel_next      = '0;
        hold_cnt_next = '0;
        capture_next  = '0;
      end
    endcase
  end

  // State register; reset has priority over every other input.
  always_ff @(posedge Clock_In) begin
    if (!Reset_n_In) begin
      state    <= IDLE;
      sel      <= '0;
      hold_cnt <= '0;
      capture  <= '0;
      word     <= '0;
    end else begin
      state    <= state_next;
      sel      <= sel_next;
      hold_cnt <= hold_cnt_next;
      capture  <= capture_next;
      word     <= word_next;
    end
  end

  assign bus.Enable_Out        = (state == SCAN);
  assign bus.Select_Out        = sel;
  assign bus.Busy_Out          = (state != IDLE);
  assign bus.Done_Out          = (state == DONE);
  assign bus.Parallel_Data_Out = word;

endmodule
